// File: rtl/jtl_pipe_pkg.sv
// Shared constants and helpers for the toggle-encoded JTL pipeline array.
package jtl_pipe_pkg;

    localparam int unsigned DEPTH_DEFAULT = 3;
    localparam int unsigned LATENCY       = DEPTH_DEFAULT + 1;
    localparam int unsigned SAT_W         = 32;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input int unsigned       w);
        logic [SAT_W-1:0] max_v;
        max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        return (v >= max_v) ? max_v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/jtl_pipe_lane.sv
// One channel: edge detect, enable gating, DEPTH-stage shift, out toggle,
// saturating delivered-pulse counter and sticky drop flag.
module jtl_pipe_lane
    import jtl_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             primed,
    input  logic             ready,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             dropped
);

    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic [DEPTH-1:0] stage_q, stage_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             det;
    logic             fire;

    always_comb begin
        // Before the first sample s1 takes in too, so the reset value is never compared.
        s0_d = in;
        s1_d = primed ? s0_q : in;

        det  = (s0_q ^ s1_q) & primed;

        stage_d    = stage_q;
        stage_d[0] = det & en & ready;
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
        end

        fire  = stage_q[DEPTH-1];
        out_d = out_q ^ fire;

        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (cnt_clr) begin
            cnt_d  = '0;
            drop_d = 1'b0;
        end else begin
            if (fire) begin
                cnt_d = CNT_W'(sat_inc(SAT_W'(cnt_q), CNT_W));
            end
            if (det & ready & ~en) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            stage_q <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign out       = out_q;
    assign pulse_cnt = cnt_q;
    assign dropped   = drop_q;

endmodule

// File: rtl/jtl_pipe_array.sv
// CH-channel toggle-encoded SFQ pipeline with shared post-reset hold-off.
module jtl_pipe_array
    import jtl_pipe_pkg::*;
#(
    parameter int unsigned CH      = 4,
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned HOLDOFF = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       in,
    input  logic [CH-1:0]       en,
    input  logic                cnt_clr,
    output logic [CH-1:0]       out,
    output logic                ready,
    output logic [CH*CNT_W-1:0] pulse_cnt,
    output logic [CH-1:0]       dropped
);

    localparam int unsigned HCNT_W = (HOLDOFF == 0) ? 1 : $clog2(HOLDOFF + 1);

    logic              primed_q, primed_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              ready_q, ready_d;

    // Hold-off counter saturates at HOLDOFF; ready latches once it gets there.
    always_comb begin
        primed_d = 1'b1;
        hcnt_d   = hcnt_q;
        if (hcnt_q != HCNT_W'(HOLDOFF)) begin
            hcnt_d = hcnt_q + HCNT_W'(1);
        end
        ready_d = ready_q | (hcnt_d == HCNT_W'(HOLDOFF));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_q <= 1'b0;
            hcnt_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            primed_q <= primed_d;
            hcnt_q   <= hcnt_d;
            ready_q  <= ready_d;
        end
    end

    assign ready = ready_q;

    for (genvar c = 0; c < int'(CH); c++) begin : g_lane
        jtl_pipe_lane #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .in        (in[c]),
            .en        (en[c]),
            .primed    (primed_q),
            .ready     (ready_q),
            .cnt_clr   (cnt_clr),
            .out       (out[c]),
            .pulse_cnt (pulse_cnt[c*CNT_W +: CNT_W]),
            .dropped   (dropped[c])
        );
    end

endmodule
